barrett_mu_precompute: RTL and testbench

// - Upstream companion of the pipelined Barrett reducer: derives the reduction constant
//   mu = floor(2^SHIFT / m) for a modulus m and hands the {m, mu} pair to the reducer.
// - Sequential restoring divider, one quotient bit per cycle, FSM-controlled.
// - Runs once per modulus change, so it is off the per-operand critical path.

---
 rtl/barrett_mu_if.sv | 23 ++
 rtl/barrett_mu_precompute.sv | 142 ++++++++++++++
 tb/tb_barrett_mu_precompute.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/barrett_mu_if.sv
// Request/result bundle between a modulus source and barrett_mu_precompute.
// Signal names are seen from the precompute block's side.
interface barrett_mu_if #(
  parameter int WIDTH = 64
);
  logic             start_i;
  logic [WIDTH-1:0] m_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] m_o;
  logic [WIDTH-1:0] mu_o;
  logic             err_o;

  modport master (
    output start_i, m_i,
    input  busy_o, valid_o, m_o, mu_o, err_o
  );

  modport slave (
    input  start_i, m_i,
    output busy_o, valid_o, m_o, mu_o, err_o
  );
endinterface

// File: rtl/barrett_mu_precompute.sv
// Derives mu = floor(2^SHIFT / m) with a bit-serial restoring divider for the Barrett reducer.
// Optional last-result cache enabled by defining BARRETT_MU_CACHE_EN.
module barrett_mu_precompute #(
  parameter int WIDTH = 64,
  parameter int SHIFT = 64
) (
  input logic         clk_i,
  input logic         rst_ni,
  barrett_mu_if.slave bus
);
  localparam int CW = $clog2(SHIFT + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(SHIFT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   r_q;
  logic [SHIFT:0]   q_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             valid_q;
  logic             err_q;
  logic [WIDTH-1:0] mo_q;
  logic [WIDTH-1:0] mu_q;

  logic             din_d;
  logic [WIDTH:0]   r_shift_d;
  logic [WIDTH:0]   r_d;
  logic             q_bit_d;
  logic [SHIFT:0]   q_d;
  logic             bad_d;
  logic             hit_d;
  logic [WIDTH-1:0] cache_mu_d;

`ifdef BARRETT_MU_CACHE_EN
  logic             cache_vld_q;
  logic [WIDTH-1:0] cache_m_q;
  logic [WIDTH-1:0] cache_mu_q;

  assign hit_d      = cache_vld_q && (cache_m_q == m_q);
  assign cache_mu_d = cache_mu_q;
`else
  assign hit_d      = 1'b0;
  assign cache_mu_d = '0;
`endif

  // One restoring-division step; the dividend 2^SHIFT has a single 1 at bit SHIFT.
  always_comb begin
    din_d     = (cnt_q == CNT_TOP);
    r_shift_d = (WIDTH + 1)'({r_q, din_d});
    if (r_shift_d >= {1'b0, m_q}) begin
      r_d     = r_shift_d - {1'b0, m_q};
      q_bit_d = 1'b1;
    end else begin
      r_d     = r_shift_d;
      q_bit_d = 1'b0;
    end
    q_d   = (SHIFT + 1)'({q_q, q_bit_d});
    bad_d = (m_q < WIDTH'(2));
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      m_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      mo_q        <= '0;
      mu_q        <= '0;
`ifdef BARRETT_MU_CACHE_EN
      cache_vld_q <= 1'b0;
      cache_m_q   <= '0;
      cache_mu_q  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            m_q     <= bus.m_i;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= CNT_TOP;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        CALC: begin
          // Rejected moduli and cache hits resolve in the first cycle, before any division step lands.
          if ((cnt_q == CNT_TOP) && (bad_d || hit_d)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            mo_q    <= m_q;
            err_q   <= bad_d;
            mu_q    <= bad_d ? '0 : cache_mu_d;
          end else if (cnt_q == '0) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            mo_q    <= m_q;
            err_q   <= 1'b0;
            mu_q    <= WIDTH'(q_d);
`ifdef BARRETT_MU_CACHE_EN
            cache_vld_q <= 1'b1;
            cache_m_q   <= m_q;
            cache_mu_q  <= WIDTH'(q_d);
`endif
          end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.err_o   = err_q;
  assign bus.m_o     = mo_q;
  assign bus.mu_o    = mu_q;
endmodule

// File: tb/tb_barrett_mu_precompute.sv
// Randomized self-checking bench for barrett_mu_precompute against a 128-bit arithmetic model.
module tb_barrett_mu_precompute;
  localparam int WIDTH = 64;
  localparam int SHIFT = 64;
`ifdef BARRETT_MU_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  bit        mc_vld;
  logic [63:0] mc_m;

  barrett_mu_if #(.WIDTH(WIDTH)) bus ();

  barrett_mu_precompute #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mu_ref(input logic [63:0] m);
    logic [127:0] num;
    num = 128'd1;
    num = num << SHIFT;
    return 64'(num / {64'd0, m});
  endfunction

  function automatic logic [63:0] barrett_red(input logic [127:0] x, input logic [63:0] m,
                                               input logic [63:0] mu);
    logic [255:0] prod;
    logic [127:0] q;
    logic [127:0] r;
    prod = {128'd0, x} * {192'd0, mu};
    q    = prod[191:64];
    r    = x - q * {64'd0, m};
    if (r >= {64'd0, m}) r = r - {64'd0, m};
    if (r >= {64'd0, m}) r = r - {64'd0, m};
    return r[63:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and check latency, result fields and the single-cycle pulse.
  task automatic do_req(input string tag, input logic [63:0] m, input bit pulse_mid,
                        output logic [63:0] mu_got);
    bit          err_e;
    logic [63:0] mu_e;
    int          lat_e;
    int          lat;
    bit          seen;
    int          extra;
    err_e = (m < 64'd2);
    mu_e  = err_e ? 64'd0 : mu_ref(m);
    lat_e = (err_e || (CACHE_ON && mc_vld && (mc_m == m))) ? 1 : SHIFT + 1;
    if (!err_e) begin
      mc_vld = 1'b1;
      mc_m   = m;
    end
    bus.start_i = 1'b1;
    bus.m_i     = m;
    step();
    bus.start_i = 1'b0;
    bus.m_i     = {$urandom, $urandom};
    check_val({tag, "_busy"}, {127'd0, bus.busy_o}, 128'd1);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 3 * SHIFT && !seen; k++) begin
      bus.start_i = (pulse_mid && k == 10) ? 1'b1 : 1'b0;
      step();
      if (bus.valid_o) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    bus.start_i = 1'b0;
    check_val({tag, "_seen"}, {127'd0, seen}, 128'd1);
    check_val({tag, "_lat"}, 128'(lat), 128'(lat_e));
    check_val({tag, "_err"}, {127'd0, bus.err_o}, {127'd0, err_e});
    check_val({tag, "_m"}, {64'd0, bus.m_o}, {64'd0, m});
    check_val({tag, "_mu"}, {64'd0, bus.mu_o}, {64'd0, mu_e});
    mu_got = bus.mu_o;
    step();
    check_val({tag, "_pulse"}, {127'd0, bus.valid_o}, 128'd0);
    check_val({tag, "_hold"}, {64'd0, bus.mu_o}, {64'd0, mu_e});
    if (pulse_mid) begin
      extra = 0;
      for (int k = 0; k < SHIFT + 8; k++) begin
        step();
        if (bus.valid_o) extra++;
      end
      check_val({tag, "_extra_valid"}, 128'(extra), 128'd0);
      check_val({tag, "_idle_busy"}, {127'd0, bus.busy_o}, 128'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, {127'd0, bus.busy_o}, 128'd0);
    check_val({tag, "_valid"}, {127'd0, bus.valid_o}, 128'd0);
    check_val({tag, "_err"}, {127'd0, bus.err_o}, 128'd0);
    check_val({tag, "_m"}, {64'd0, bus.m_o}, 128'd0);
    check_val({tag, "_mu"}, {64'd0, bus.mu_o}, 128'd0);
  endtask

  initial begin
    logic [63:0]  mu;
    logic [63:0]  m;
    logic [127:0] x;
    int           vcnt;
    n_cmp       = 0;
    n_err       = 0;
    mc_vld      = 1'b0;
    mc_m        = 64'd0;
    bus.start_i = 1'b0;
    bus.m_i     = 64'd0;
    rst_n       = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    do_req("m3", 64'd3, 1'b0, mu);
    check_val("m3_const", {64'd0, mu}, {64'd0, 64'h5555_5555_5555_5555});
    do_req("m3_again", 64'd3, 1'b0, mu);
    do_req("m5", 64'd5, 1'b0, mu);
    check_val("m5_const", {64'd0, mu}, {64'd0, 64'h3333_3333_3333_3333});
    do_req("m2", 64'd2, 1'b0, mu);
    check_val("m2_const", {64'd0, mu}, {64'd0, 64'h8000_0000_0000_0000});
    do_req("m2p32", 64'h1_0000_0000, 1'b0, mu);
    check_val("m2p32_const", {64'd0, mu}, {64'd0, 64'h1_0000_0000});
    do_req("mmax", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, mu);
    check_val("mmax_const", {64'd0, mu}, 128'd1);
    do_req("m1", 64'd1, 1'b0, mu);
    do_req("m0", 64'd0, 1'b0, mu);
    do_req("mmax_again", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, mu);

    m = 64'h9215_3525;
    do_req("mb", m, 1'b0, mu);
    for (int i = 0; i < 8; i++) begin
      x = {64'd0, $urandom, $urandom} % ({64'd0, m} << 2);
      check_val("barrett_r", {64'd0, barrett_red(x, m, mu)}, x % {64'd0, m});
    end

    for (int i = 0; i < 10; i++) begin
      m = {$urandom, $urandom} >> $urandom_range(0, 63);
      do_req("rand", m, 1'b0, mu);
    end

    do_req("mid_start", 64'd7, 1'b1, mu);

    // Abort a computation when the counter sits at 30.
    bus.start_i = 1'b1;
    bus.m_i     = 64'h1234_5678_9ABC_DEF1;
    step();
    bus.start_i = 1'b0;
    repeat (SHIFT - 30) step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    mc_vld = 1'b0;
    step();
    rst_n = 1'b1;
    vcnt  = 0;
    for (int k = 0; k < SHIFT + 8; k++) begin
      step();
      if (bus.valid_o) vcnt++;
    end
    check_val("mid_rst_no_valid", 128'(vcnt), 128'd0);
    do_req("post_rst_m3", 64'd3, 1'b0, mu);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
